// File: rtl/packet_fifo_sf.sv
// Store-and-forward packet FIFO: words become readable only once their packet's EOD word is written.
// Packets can be aborted by the writer, and a packet that overflows the buffer is discarded automatically.
module packet_fifo_sf #(
  parameter int DW         = 8,
  parameter int AW         = 14,
  parameter int AEMPTY_CNT = 1500,
  parameter int AFULL_CNT  = 16000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          eod_in,
  input  logic          drop_in,
  output logic          full_flag,
  output logic          afull_flag,
  output logic          ovf_drop,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          eod_out,
  output logic          rvalid,
  output logic          empty_flag,
  output logic          aempty_flag,
  output logic [AW:0]   pkt_count,
  output logic [AW:0]   level
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] DEPTH_L  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_L  = (AW+1)'(AFULL_CNT);
  localparam logic [AW:0] AEMPTY_L = (AW+1)'(AEMPTY_CNT);

  logic [DW:0]   mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
  logic [AW:0]   pkt_count_q, pkt_count_d;
  logic          ovf_q, ovf_d, ovf_drop_q, ovf_drop_d;
  logic          rvalid_q, eod_out_q, afull_q, aempty_q;
  logic [DW-1:0] dout_q;
  logic [AW:0]   occupancy, level_w;
  logic [DW:0]   rd_word;
  logic          mem_we, commit, rd_en, eod_read;

  // Occupancy includes uncommitted words; level counts only what the reader may see.
  assign occupancy  = wptr_q - rptr_q;
  assign level_w    = cptr_q - rptr_q;
  assign full_flag  = (occupancy == DEPTH_L);
  assign empty_flag = (cptr_q == rptr_q);
  assign level      = level_w;

  assign rd_en    = re & ~empty_flag;
  assign rd_word  = mem_q[rptr_q[AW-1:0]];
  assign eod_read = rd_en & rd_word[0];
  assign rptr_d   = rptr_q + {{AW{1'b0}}, rd_en};

  // Drop beats everything; once overflowed, the rest of the packet is swallowed until its EOD.
  always_comb begin
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    ovf_d      = ovf_q;
    ovf_drop_d = 1'b0;
    mem_we     = 1'b0;
    commit     = 1'b0;
    if (drop_in) begin
      wptr_d = cptr_q;
      ovf_d  = 1'b0;
    end else if (we) begin
      if (ovf_q || full_flag) begin
        ovf_d = 1'b1;
        if (eod_in) begin
          wptr_d     = cptr_q;
          ovf_d      = 1'b0;
          ovf_drop_d = 1'b1;
        end
      end else begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (eod_in) begin
          cptr_d = wptr_q + 1'b1;
          commit = 1'b1;
        end
      end
    end
  end

  assign pkt_count_d = pkt_count_q + {{AW{1'b0}}, commit} - {{AW{1'b0}}, eod_read};

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q[AW-1:0]] <= {din, eod_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      cptr_q      <= '0;
      rptr_q      <= '0;
      pkt_count_q <= '0;
      ovf_q       <= 1'b0;
      ovf_drop_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      dout_q      <= '0;
      eod_out_q   <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end else begin
      wptr_q      <= wptr_d;
      cptr_q      <= cptr_d;
      rptr_q      <= rptr_d;
      pkt_count_q <= pkt_count_d;
      ovf_q       <= ovf_d;
      ovf_drop_q  <= ovf_drop_d;
      rvalid_q    <= rd_en;
      if (rd_en) {dout_q, eod_out_q} <= rd_word;
      afull_q     <= (occupancy >= AFULL_L);
      aempty_q    <= (level_w <= AEMPTY_L);
    end
  end

  assign afull_flag  = afull_q;
  assign aempty_flag = aempty_q;
  assign ovf_drop    = ovf_drop_q;
  assign rvalid      = rvalid_q;
  assign dout        = dout_q;
  assign eod_out     = eod_out_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_packet_fifo_sf.sv
// Self-checking bench for packet_fifo_sf (DEPTH 16): a behavioural model tracks occupancy and flags,
// and a scoreboard queue holds committed words until the DUT presents them on rvalid.
module tb_packet_fifo_sf;

  logic       clk = 1'b0;
  logic       rst, we, eodIn, dropIn, re;
  logic [7:0] din;
  logic       fullFlag, afullFlag, ovfDrop, eodOut, rvalid, emptyFlag, aemptyFlag;
  logic [7:0] dout;
  logic [4:0] pktCount, level;

  int assertCount = 0;
  int failCount   = 0;

  logic [8:0] expQ[$];
  logic [8:0] pendQ[$];
  int         mOcc, mLevel, mPkt;
  bit         mOvf, mRvalid, mOvfDrop, mAfull, mAempty;
  logic [7:0] mDout;
  logic       mEodOut;

  always #5 clk = ~clk;

  packet_fifo_sf #(.DW(8), .AW(4), .AEMPTY_CNT(2), .AFULL_CNT(12)) dut (
    .clk(clk), .rst(rst), .din(din), .we(we), .eod_in(eodIn), .drop_in(dropIn),
    .full_flag(fullFlag), .afull_flag(afullFlag), .ovf_drop(ovfDrop), .re(re),
    .dout(dout), .eod_out(eodOut), .rvalid(rvalid), .empty_flag(emptyFlag),
    .aempty_flag(aemptyFlag), .pkt_count(pktCount), .level(level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    pendQ.delete();
    mOcc = 0; mLevel = 0; mPkt = 0; mOvf = 0;
    mRvalid = 0; mOvfDrop = 0; mAfull = 0; mAempty = 1;
    mDout = '0; mEodOut = 1'b0;
  endtask

  // Called at posedge+1: checks current outputs, drives inputs for the coming edge, advances the model.
  task automatic applyStimulus(input bit r, input bit w, input logic [7:0] d, input bit e,
                               input bit dp, input bit rd);
    logic [8:0] cur;
    bit full, empty, rdEn, nRvalid, nOvfDrop, nAfull, nAempty;
    rst = r; we = w; din = d; eodIn = e; dropIn = dp; re = rd;
    if (mRvalid && expQ.size() > 0) begin
      cur = expQ.pop_front();
      mDout = cur[8:1];
      mEodOut = cur[0];
    end
    checkOutput("rvalid", rvalid, mRvalid);
    checkOutput("dout", dout, mDout);
    checkOutput("eod_out", eodOut, mEodOut);
    checkOutput("empty_flag", emptyFlag, mLevel == 0);
    checkOutput("full_flag", fullFlag, mOcc == 16);
    checkOutput("level", level, mLevel);
    checkOutput("pkt_count", pktCount, mPkt);
    checkOutput("afull_flag", afullFlag, mAfull);
    checkOutput("aempty_flag", aemptyFlag, mAempty);
    checkOutput("ovf_drop", ovfDrop, mOvfDrop);

    full = (mOcc == 16);
    empty = (mLevel == 0);
    nAfull = (mOcc >= 12);
    nAempty = (mLevel <= 2);
    nOvfDrop = 0;
    rdEn = rd && !empty;
    nRvalid = rdEn;
    if (rdEn) begin
      mLevel--;
      mOcc--;
      if (expQ[0][0]) mPkt--;
    end
    if (dp) begin
      mOcc -= pendQ.size();
      pendQ.delete();
      mOvf = 0;
    end else if (w) begin
      if (mOvf || full) begin
        mOvf = 1;
        if (e) begin
          mOcc -= pendQ.size();
          pendQ.delete();
          mOvf = 0;
          nOvfDrop = 1;
        end
      end else begin
        pendQ.push_back({d, e});
        mOcc++;
        if (e) begin
          foreach (pendQ[i]) expQ.push_back(pendQ[i]);
          mLevel += pendQ.size();
          mPkt++;
          pendQ.delete();
        end
      end
    end
    if (r) begin
      resetModel();
      nRvalid = 0; nOvfDrop = 0; nAfull = 0; nAempty = 1;
    end
    @(posedge clk);
    #1;
    mRvalid = nRvalid; mOvfDrop = nOvfDrop; mAfull = nAfull; mAempty = nAempty;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic readWords(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1);
  endtask

  task automatic writePacket(input logic [7:0] base, input int n, input bit withEod);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 8'(base + i), withEod && (i == n - 1), 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; we = 0; din = '0; eodIn = 0; dropIn = 0; re = 0;
    resetModel();
    @(posedge clk);
    #1;

    $display("[TB] basic packet");
    writePacket(8'h10, 5, 1);
    readWords(5);
    idle(2);

    $display("[TB] drop");
    writePacket(8'h20, 4, 0);
    applyStimulus(0, 1, 8'h24, 0, 1, 0);
    writePacket(8'h30, 2, 1);
    readWords(4);
    idle(1);

    $display("[TB] overflow");
    writePacket(8'h40, 10, 1);
    writePacket(8'h50, 9, 1);
    idle(1);
    readWords(12);
    idle(1);

    $display("[TB] oversize packet and write at full with read");
    writePacket(8'h60, 20, 1);
    idle(1);
    writePacket(8'h80, 16, 1);
    applyStimulus(0, 1, 8'hAA, 1, 0, 1);
    idle(1);
    readWords(17);
    idle(1);

    $display("[TB] wrap and flags");
    for (int p = 0; p < 40; p++)
      for (int k = 0; k < 3; k++)
        applyStimulus(0, 1, 8'(p * 3 + k), k == 2, 0, (mOcc >= 13) || ($urandom_range(0, 1) == 1));
    readWords(20);
    idle(1);

    $display("[TB] simultaneous commit and EOD read");
    writePacket(8'hC0, 2, 1);
    applyStimulus(0, 1, 8'hD0, 0, 0, 1);
    applyStimulus(0, 1, 8'hD1, 1, 0, 1);
    readWords(3);
    idle(1);

    $display("[TB] reset mid-packet");
    writePacket(8'hE0, 2, 1);
    writePacket(8'hE2, 3, 0);
    applyStimulus(1, 1, 8'hE5, 0, 0, 1);
    idle(1);
    writePacket(8'hF0, 2, 1);
    readWords(3);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
